// File: rtl/bram_tile_sched_if.sv
// Signal bundle for bram_tile_sched: tile control/config, upstream word stream,
// single-port BRAM connection, downstream window stream and status.
interface bram_tile_sched_if #(
    parameter int DW  = 64,
    parameter int WAW = 7,
    parameter int RAW = 13
);
    logic              start;
    logic [7:0]        cfg_wr_count;
    logic [RAW-1:0]    cfg_rd_base;
    logic [RAW-1:0]    cfg_rd_stride;
    logic [RAW-1:0]    cfg_rd_count;
    logic              s_valid;
    logic [DW-1:0]     s_data;
    logic              s_ready;
    logic              bram_we;
    logic [WAW-1:0]    bram_wr_addr;
    logic [DW-1:0]     bram_data_in;
    logic [RAW-1:0]    bram_rd_addr;
    logic [2*DW-1:0]   bram_data_out;
    logic [RAW-1:0]    bram_addr;
    logic              m_valid;
    logic [2*DW-1:0]   m_data;
    logic [RAW-1:0]    m_addr;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              err;

    // The scheduler side.
    modport master (
        input  start, cfg_wr_count, cfg_rd_base, cfg_rd_stride, cfg_rd_count,
        input  s_valid, s_data, bram_data_out, bram_addr, m_ready,
        output s_ready, bram_we, bram_wr_addr, bram_data_in, bram_rd_addr,
        output m_valid, m_data, m_addr, busy, done, err
    );

    // The surrounding loader / BRAM / PE-input side.
    modport slave (
        output start, cfg_wr_count, cfg_rd_base, cfg_rd_stride, cfg_rd_count,
        output s_valid, s_data, bram_data_out, bram_addr, m_ready,
        input  s_ready, bram_we, bram_wr_addr, bram_data_in, bram_rd_addr,
        input  m_valid, m_data, m_addr, busy, done, err
    );
endinterface

// File: rtl/bram_tile_sched.sv
// Per-tile sequencer for the single-port line buffer BRAM: loads words from
// upstream, then issues strided byte-address reads and streams out windows.
module bram_tile_sched #(
    parameter int DW   = 64,
    parameter int WAW  = 7,
    parameter int RAW  = 13,
    parameter int SKID = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_tile_sched_if.master bus
);
    localparam int OW = $clog2(SKID + 1);

    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;
    state_t state;

    logic [7:0]      wr_total;
    logic [7:0]      wr_ptr;
    logic [RAW-1:0]  rd_next;
    logic [RAW-1:0]  rd_stride;
    logic [RAW-1:0]  rd_left;
    logic            inflight;
    logic [OW-1:0]   occ;
    logic [2*DW-1:0] q_data [SKID];
    logic [RAW-1:0]  q_addr [SKID];

    logic            pop;
    logic            accept;
    logic            last_wr;
    logic            issue;
    logic            last_rd;
    logic [OW:0]     pending;
    logic [OW-1:0]   push_idx;

    // A pop in the same cycle frees a slot, which is what allows one read per cycle.
    assign pop      = (occ != '0) && bus.m_ready;
    assign accept   = bus.s_ready && bus.s_valid;
    assign last_wr  = accept && (wr_ptr == wr_total - 8'd1);
    assign pending  = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);
    assign issue    = (state == READ) && (rd_left != '0) && (pending < (OW+1)'(SKID));
    assign last_rd  = issue && (rd_left == RAW'(1));
    assign push_idx = occ - OW'(pop);

    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = q_data[0];
    assign bus.m_addr  = q_addr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wr_total         <= '0;
            wr_ptr           <= '0;
            rd_next          <= '0;
            rd_stride        <= '0;
            rd_left          <= '0;
            bus.s_ready      <= 1'b0;
            bus.bram_we      <= 1'b0;
            bus.bram_wr_addr <= '0;
            bus.bram_data_in <= '0;
            bus.bram_rd_addr <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.bram_we <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        wr_total  <= (bus.cfg_wr_count > 8'd128) ? 8'd128 : bus.cfg_wr_count;
                        wr_ptr    <= '0;
                        rd_next   <= bus.cfg_rd_base;
                        rd_stride <= bus.cfg_rd_stride;
                        rd_left   <= bus.cfg_rd_count;
                        bus.err   <= 1'b0;
                        bus.busy  <= 1'b1;
                        if (bus.cfg_wr_count != 8'd0) begin
                            state       <= LOAD;
                            bus.s_ready <= 1'b1;
                        end else if (bus.cfg_rd_count != '0) begin
                            state <= READ;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bus.bram_we      <= 1'b1;
                        bus.bram_wr_addr <= wr_ptr[WAW-1:0];
                        bus.bram_data_in <= bus.s_data;
                        wr_ptr           <= wr_ptr + 8'd1;
                        if (last_wr) begin
                            bus.s_ready <= 1'b0;
                            if (rd_left != '0) begin
                                state <= READ;
                            end else begin
                                state    <= DONE;
                                bus.done <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        bus.bram_rd_addr <= rd_next;
                        rd_next          <= rd_next + rd_stride;
                        rd_left          <= rd_left - RAW'(1);
                        // Word 127 has no successor, so the upper half of the window wraps.
                        if (rd_next[RAW-1:3] == (RAW-3)'(127)) begin
                            bus.err <= 1'b1;
                        end
                        if (last_rd) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((occ == '0) && !inflight) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid buffer kept as a shift register so the head entry drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            for (int i = 0; i < SKID; i++) begin
                q_data[i] <= '0;
                q_addr[i] <= '0;
            end
        end else begin
            inflight <= issue;
            occ      <= occ + OW'(inflight) - OW'(pop);
            if (pop) begin
                for (int i = 0; i < SKID - 1; i++) begin
                    q_data[i] <= q_data[i+1];
                    q_addr[i] <= q_addr[i+1];
                end
            end
            if (inflight) begin
                for (int i = 0; i < SKID; i++) begin
                    if (push_idx == OW'(i)) begin
                        q_data[i] <= bus.bram_data_out;
                        q_addr[i] <= bus.bram_addr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bram_tile_sched.sv
// Directed bench for bram_tile_sched with a behavioural 128x64 BRAM that
// returns {word+1, word} for the presented read byte address.
module tb_bram_tile_sched;
    logic clk;
    logic rst_n;
    logic mem_init;
    int   tests;
    int   fails;

    logic [63:0] W [4];
    logic [63:0] mem [128];
    logic [6:0]  rd_word;

    bram_tile_sched_if #(.DW(64), .WAW(7), .RAW(13)) bus ();

    bram_tile_sched #(.DW(64), .WAW(7), .RAW(13), .SKID(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: the scheduler's registered read address is the BRAM address register.
    assign rd_word           = bus.bram_rd_addr[9:3];
    assign bus.bram_data_out = {mem[rd_word + 7'd1], mem[rd_word]};
    assign bus.bram_addr     = bus.bram_rd_addr;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= {56'hA0_0000_0000_0000, 8'(i)};
        end else if (bus.bram_we) begin
            mem[bus.bram_wr_addr] <= bus.bram_data_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if ({bus.s_ready, bus.bram_we, bus.m_valid, bus.busy, bus.done, bus.err} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {bus.s_ready, bus.bram_we, bus.m_valid, bus.busy, bus.done, bus.err});
        end
        tests++;
        if (bus.bram_wr_addr !== 7'd0 || bus.bram_rd_addr !== 13'd0 || bus.bram_data_in !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_bram_regs: got wa=%h ra=%h di=%h expected all 0",
                     bus.bram_wr_addr, bus.bram_rd_addr, bus.bram_data_in);
        end
        tests++;
        if (bus.m_data !== 128'd0 || bus.m_addr !== 13'd0) begin
            fails++;
            $display("[TB] FAIL reset_output: got data=%h addr=%h expected 0", bus.m_data, bus.m_addr);
        end
        repeat (3) tick();
        mem_init = 1'b0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int donecnt = 0;
        bus.cfg_wr_count = 8'd4; bus.cfg_rd_base = 13'd0; bus.cfg_rd_stride = 13'd8; bus.cfg_rd_count = 13'd2;
        bus.start = 1'b1; bus.s_valid = 1'b1; bus.s_data = W[0]; bus.m_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            bus.start = 1'b0;
            if (c <= 6) begin
                tests++;
                if (bus.s_ready !== (c <= 4)) begin
                    fails++;
                    $display("[TB] FAIL load_s_ready c%0d: got %b expected %b", c, bus.s_ready, (c <= 4));
                end
                tests++;
                if (bus.bram_we !== (c >= 2 && c <= 5)) begin
                    fails++;
                    $display("[TB] FAIL load_we c%0d: got %b expected %b", c, bus.bram_we, (c >= 2 && c <= 5));
                end
                if (c >= 2 && c <= 5) begin
                    tests++;
                    if (bus.bram_wr_addr !== 7'(c - 2) || bus.bram_data_in !== W[c-2]) begin
                        fails++;
                        $display("[TB] FAIL load_write c%0d: got a=%0d d=%h expected a=%0d d=%h",
                                 c, bus.bram_wr_addr, bus.bram_data_in, c - 2, W[c-2]);
                    end
                end
            end
            if (c == 7) begin
                tests++;
                if (bus.bram_rd_addr !== 13'd8 || bus.m_valid !== 1'b1 || bus.m_data !== {W[1], W[0]}) begin
                    fails++;
                    $display("[TB] FAIL load_then_read: got ra=%0d v=%b d=%h expected ra=8 v=1 d=%h",
                             bus.bram_rd_addr, bus.m_valid, bus.m_data, {W[1], W[0]});
                end
            end
            if (bus.done) donecnt++;
            if (c == 10) begin
                tests++;
                if (bus.done !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL load_done_time: got %b expected 1", bus.done);
                end
            end
            if (c <= 4) bus.s_data = W[c-1];
            else bus.s_valid = (c == 5);
        end
        tests++;
        if (donecnt != 1) begin
            fails++;
            $display("[TB] FAIL load_done_count: got %0d expected 1", donecnt);
        end
    endtask

    task automatic test_read();
        bus.cfg_wr_count = 8'd0; bus.cfg_rd_base = 13'd0; bus.cfg_rd_stride = 13'd8; bus.cfg_rd_count = 13'd3;
        bus.start = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.start = 1'b0;
            tests++;
            if (bus.m_valid !== (c >= 3 && c <= 5)) begin
                fails++;
                $display("[TB] FAIL read_valid c%0d: got %b expected %b", c, bus.m_valid, (c >= 3 && c <= 5));
            end
            if (c >= 3 && c <= 5) begin
                tests++;
                if (bus.m_addr !== 13'((c - 3) * 8) || bus.m_data !== {W[c-2], W[c-3]}) begin
                    fails++;
                    $display("[TB] FAIL read_beat c%0d: got a=%0d d=%h expected a=%0d d=%h",
                             c, bus.m_addr, bus.m_data, (c - 3) * 8, {W[c-2], W[c-3]});
                end
            end
            if (c >= 2 && c <= 4) begin
                tests++;
                if (bus.bram_rd_addr !== 13'((c - 2) * 8)) begin
                    fails++;
                    $display("[TB] FAIL read_issue c%0d: got %0d expected %0d", c, bus.bram_rd_addr, (c - 2) * 8);
                end
            end
            tests++;
            if (bus.done !== (c == 7) || bus.busy !== (c <= 7)) begin
                fails++;
                $display("[TB] FAIL read_status c%0d: got done=%b busy=%b expected done=%b busy=%b",
                         c, bus.done, bus.busy, (c == 7), (c <= 7));
            end
        end
        tests++;
        if (bus.err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL read_err: got %b expected 0", bus.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] ea;
        bus.cfg_wr_count = 8'd0; bus.cfg_rd_base = 13'd0; bus.cfg_rd_stride = 13'd8; bus.cfg_rd_count = 13'd3;
        bus.start = 1'b1; bus.m_ready = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            bus.start = 1'b0;
            ea = (c <= 8) ? 13'd0 : 13'((c - 8) * 8);
            tests++;
            if (bus.m_valid !== (c >= 3 && c <= 10)) begin
                fails++;
                $display("[TB] FAIL bp_valid c%0d: got %b expected %b", c, bus.m_valid, (c >= 3 && c <= 10));
            end
            if (c >= 3 && c <= 10) begin
                tests++;
                if (bus.m_addr !== ea || bus.m_data !== {W[ea/8+1], W[ea/8]}) begin
                    fails++;
                    $display("[TB] FAIL bp_beat c%0d: got a=%0d d=%h expected a=%0d d=%h",
                             c, bus.m_addr, bus.m_data, ea, {W[ea/8+1], W[ea/8]});
                end
            end
            if (c >= 2) begin
                tests++;
                if (bus.bram_rd_addr !== ((c == 2) ? 13'd0 : (c <= 8) ? 13'd8 : 13'd16)) begin
                    fails++;
                    $display("[TB] FAIL bp_issue c%0d: got %0d", c, bus.bram_rd_addr);
                end
            end
            tests++;
            if (bus.done !== (c == 12)) begin
                fails++;
                $display("[TB] FAIL bp_done c%0d: got %b expected %b", c, bus.done, (c == 12));
            end
            bus.m_ready = (c >= 8);
            if (c == 5) begin
                bus.start = 1'b1; bus.cfg_rd_base = 13'd512; bus.cfg_rd_count = 13'd5;
            end
        end
    endtask

    task automatic test_empty();
        bus.cfg_wr_count = 8'd0; bus.cfg_rd_count = 13'd0; bus.start = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.start = 1'b0;
            tests++;
            if (bus.busy !== (c == 1) || bus.done !== (c == 1) || bus.bram_we !== 1'b0 || bus.m_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL empty c%0d: got busy=%b done=%b we=%b v=%b expected %b %b 0 0",
                         c, bus.busy, bus.done, bus.bram_we, bus.m_valid, (c == 1), (c == 1));
            end
        end
    endtask

    task automatic test_err();
        bus.cfg_wr_count = 8'd0; bus.cfg_rd_base = 13'd1016; bus.cfg_rd_stride = 13'd8; bus.cfg_rd_count = 13'd1;
        bus.start = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.start = 1'b0;
            tests++;
            if (bus.err !== (c >= 2)) begin
                fails++;
                $display("[TB] FAIL err_flag c%0d: got %b expected %b", c, bus.err, (c >= 2));
            end
            if (c == 3) begin
                tests++;
                if (bus.m_valid !== 1'b1 || bus.m_addr !== 13'd1016 || bus.m_data !== {W[0], 64'hA000_0000_0000_007F}) begin
                    fails++;
                    $display("[TB] FAIL err_window: got v=%b a=%0d d=%h", bus.m_valid, bus.m_addr, bus.m_data);
                end
            end
            if (c == 5) begin
                tests++;
                if (bus.done !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL err_done: got %b expected 1", bus.done);
                end
            end
        end
        bus.cfg_rd_count = 13'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_clear: got %b expected 0", bus.err);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bus.cfg_wr_count = 8'd0; bus.cfg_rd_base = 13'd0; bus.cfg_rd_stride = 13'd8; bus.cfg_rd_count = 13'd3;
        bus.start = 1'b1; bus.m_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tests++;
        if (bus.m_valid !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_setup: got v=%b busy=%b expected 1 1", bus.m_valid, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.m_valid, bus.busy, bus.done, bus.err, bus.s_ready, bus.bram_we} !== 6'b0 ||
            bus.bram_rd_addr !== 13'd0 || bus.m_data !== 128'd0 || bus.m_addr !== 13'd0) begin
            fails++;
            $display("[TB] FAIL mid_reset: got v=%b busy=%b done=%b ra=%0d a=%0d expected all 0",
                     bus.m_valid, bus.busy, bus.done, bus.bram_rd_addr, bus.m_addr);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 2) rst_n = 1'b1;
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL mid_quiet c%0d: got done=%b busy=%b v=%b expected 0 0 0",
                         c, bus.done, bus.busy, bus.m_valid);
            end
        end
        bus.cfg_rd_base = 13'd8; bus.cfg_rd_count = 13'd1; bus.start = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.start = 1'b0;
            tests++;
            if (bus.m_valid !== (c == 3) || bus.done !== (c == 5)) begin
                fails++;
                $display("[TB] FAIL clean_status c%0d: got v=%b done=%b expected %b %b",
                         c, bus.m_valid, bus.done, (c == 3), (c == 5));
            end
            if (c == 3) begin
                tests++;
                if (bus.m_addr !== 13'd8 || bus.m_data !== {W[2], W[1]}) begin
                    fails++;
                    $display("[TB] FAIL clean_beat: got a=%0d d=%h expected a=8 d=%h", bus.m_addr, bus.m_data, {W[2], W[1]});
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        W[0] = 64'h1111_1111_1111_1111;
        W[1] = 64'h2222_2222_2222_2222;
        W[2] = 64'h3333_3333_3333_3333;
        W[3] = 64'h4444_4444_4444_4444;
        mem_init = 1'b1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.cfg_wr_count = 8'd0;
        bus.cfg_rd_base = 13'd0;
        bus.cfg_rd_stride = 13'd0;
        bus.cfg_rd_count = 13'd0;
        bus.s_valid = 1'b0;
        bus.s_data = 64'd0;
        bus.m_ready = 1'b0;
        test_reset();
        test_load();
        test_read();
        test_back_to_back();
        test_empty();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bram_tile_sched.md
Name: bram_tile_sched

Overview:
- Sequencer for the 128x64-bit line buffer BRAM. The BRAM has one port: a cycle is either a write or a read.
- The block runs in two phases per tile:
  - LOAD: streams a programmed number of 64-bit words from an upstream valid/ready source into the BRAM.
  - READ: issues a programmed sequence of byte-granular read addresses (base + k*stride) and returns each 128-bit window, tagged with its address, on a valid/ready output.
- Sits between the feature-map loader and the PE-array input stage.

Parameters:
- DW, 64, BRAM word width.
- WAW, 7, BRAM write/word address width (128 words).
- RAW, 13, read byte-address width (word index = rd_addr>>3).
- SKID, 2, output buffer depth (entries).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a tile; ignored while busy=1.
- cfg_wr_count  in  8  words to load, 0..128; values >128 are treated as 128.
- cfg_rd_base  in  RAW  first read byte address.
- cfg_rd_stride  in  RAW  byte increment between reads.
- cfg_rd_count  in  RAW  number of reads, 0..8191.
- s_valid  in  1  upstream word valid.
- s_data  in  DW  upstream word.
- s_ready  out  1  block accepts s_data.
- bram_we  out  1  BRAM write enable.
- bram_wr_addr  out  WAW  BRAM write address.
- bram_data_in  out  DW  BRAM write data.
- bram_rd_addr  out  RAW  BRAM read byte address.
- bram_data_out  in  2*DW  BRAM read data, registered, 1-cycle latency.
- bram_addr  in  RAW  BRAM echoed read address.
- m_valid  out  1  output window valid.
- m_data  out  2*DW  output window.
- m_addr  out  RAW  byte address of the window.
- m_ready  in  1  downstream accept.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse at tile end.
- err  out  1  sticky out-of-range flag; cleared on the next accepted start.

Behaviour:
- Reset (async, rst_n=0), all outputs go to:
  - state IDLE, s_ready=0, bram_we=0;
  - bram_wr_addr=0, bram_rd_addr=0, bram_data_in=0;
  - m_valid=0, m_data=0, m_addr=0;
  - busy=0, done=0, err=0;
  - skid buffer empty, in-flight flag cleared.
- Reset mid-tile: the tile is abandoned and no done pulse is issued.
- Config is latched on the accepted start.
- State machine:
  - IDLE --start--> LOAD if wr_count>0; else READ if rd_count>0; else DONE.
  - LOAD --last write--> READ if rd_count>0, else DONE.
  - READ --last read issued--> DRAIN.
  - DRAIN --skid empty and nothing in flight--> DONE.
  - DONE --one cycle--> IDLE. done=1 only in DONE.
- busy=1 in every state except IDLE.
- LOAD:
  - s_ready=1 throughout LOAD.
  - On s_valid&&s_ready the block drives, registered, in the next cycle: bram_we=1, bram_wr_addr=write counter (starting at 0), bram_data_in=s_data.
  - The counter increments per accepted word.
  - s_ready drops in the cycle after the last word is accepted.
  - bram_we=0 in every other cycle and every other state.
- READ issue rule:
  - A read is issued in cycle t only if (skid occupancy + in-flight) < SKID, counting a pop by m_ready&&m_valid in cycle t as freeing a slot.
  - On issue: bram_rd_addr is registered with the current address, and the in-flight flag is set for the cycle the BRAM samples it.
  - One cycle later, bram_data_out and bram_addr are pushed into the skid buffer.
  - The address advances by stride, modulo 2^RAW.
  - bram_rd_addr holds its last value when no read is issued.
- Sustained throughput is one read per cycle when m_ready=1 constantly.
- Latency from first issue to m_valid is 2 cycles: BRAM register plus skid register.
- Output ordering:
  - m_valid=1 whenever the skid buffer is non-empty; m_data/m_addr show the oldest entry.
  - Entries are held stable while m_valid&&!m_ready; no drop and no duplicate.
- Range check: if an issued address has word index (addr>>3)==127, err is set because the upper 64 bits would wrap. The read is still issued and delivered.
- LOAD and READ never overlap, so a write never masks a read.
- A start pulse during busy is ignored and leaves the config unchanged.

Test Plan:
- Load 4 words 0x11..,0x22..,0x33..,0x44.., s_valid held high -> bram_we high 4 consecutive cycles, wr_addr 0..3, then state READ.
- base=0, stride=8, count=3, m_ready=1 -> m_addr 0,8,16 on consecutive cycles; first m_valid 2 cycles after first issue; done pulses once after the last beat.
- Same as previous, but m_ready low for 5 cycles after the first m_valid -> m_data/m_addr held; at most 2 reads outstanding; all 3 windows delivered in order with no duplicates.
- wr_count=0, rd_count=0 -> busy high for 1 cycle, done pulse, no bram_we and no m_valid.
- base=1016 (word 127), count=1 -> err=1, window delivered; next accepted start clears err.
- rst_n low during READ with 1 entry buffered -> all outputs return to 0 immediately; a new start then runs a clean tile.
